// File: rtl/demux4_stream_pkg.sv
// Shared constants and types for the 1:4 byte-stream demultiplexer.
package demux_pkg;
    localparam int N_CH      = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef logic [1:0] ch_sel_t;
endpackage

// File: rtl/demux4_stream_if.sv
// Producer-side stream and four consumer channels of the demultiplexer.
interface demux4_stream_if #(parameter int WIDTH = demux_pkg::DEF_WIDTH);
    import demux_pkg::*;

    logic [WIDTH-1:0]      in_data;
    ch_sel_t               in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  rr_en;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_valid, rr_en, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, rr_en, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux4_stream_slot.sv
// Single-entry output register for one channel; a load on the draining cycle
// replaces the payload without a bubble.
module stream_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/demux4_stream.sv
// Steers one valid/ready byte stream to four buffered channels, either by explicit
// select or round-robin, with per-channel accepted-beat counters.
module demux4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    demux4_stream_if.slave        bus,
    output logic [N_CH*CNT_W-1:0] beat_cnt_o,
    output ch_sel_t               rr_ptr_o
);
    ch_sel_t          dest;
    ch_sel_t          rr_ptr_q, rr_ptr_d;
    logic             accept;
    logic [N_CH-1:0]  load;
    logic [N_CH-1:0]  slot_valid;
    logic [WIDTH-1:0] slot_data [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    assign dest         = bus.rr_en ? rr_ptr_q : bus.in_sel;
    assign bus.in_ready = ~slot_valid[dest] | bus.out_ready[dest];
    assign accept       = bus.in_valid & bus.in_ready;

    // load is forced low without accept so an X select cannot reach channel state
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && bus.rr_en) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
        for (int k = 0; k < N_CH; k++) begin
            load[k]  = accept && (dest == ch_sel_t'(k));
            cnt_d[k] = load[k] ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        stream_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load_i  (load[g]),
            .data_i  (bus.in_data),
            .ready_i (bus.out_ready[g]),
            .valid_o (slot_valid[g]),
            .data_o  (slot_data[g])
        );
    end

    always_comb begin
        bus.out_data = '0;
        beat_cnt_o   = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.out_data[k*WIDTH +: WIDTH] = slot_data[k];
            beat_cnt_o[k*CNT_W +: CNT_W]   = cnt_q[k];
        end
    end

    assign bus.out_valid = slot_valid;
    assign rr_ptr_o      = rr_ptr_q;
endmodule

// File: tb/tb_demux4_stream.sv
// Directed scenario bench for demux4_stream with hand-computed expectations.
module tb_demux4_stream;
    import demux_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] beat_cnt;
    ch_sel_t     rr_ptr;
    int          vectors = 0;
    int          errors  = 0;

    demux4_stream_if #(.WIDTH(8)) bus ();

    demux4_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .beat_cnt_o (beat_cnt),
        .rr_ptr_o   (rr_ptr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chd(input int k);
        return bus.out_data[k*8 +: 8];
    endfunction

    function automatic logic [7:0] cnt(input int k);
        return beat_cnt[k*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 2'd0;
        bus.rr_en     = 1'b0;
        bus.out_ready = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid got %b want 0000", bus.out_valid);
        end
        vectors++;
        if (beat_cnt !== 32'h0 || rr_ptr !== 2'd0) begin
            errors++; $display("FAIL reset_cnt got %h/%0d want 0/0", beat_cnt, rr_ptr);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 4'b0100 || chd(2) !== 8'hA5) begin
            errors++; $display("FAIL single got valid %b data %h want 0100 a5", bus.out_valid, chd(2));
        end
        vectors++;
        if (beat_cnt !== 32'h0001_0000) begin
            errors++; $display("FAIL single_cnt got %h want 00010000", beat_cnt);
        end
    endtask

    task automatic test_stall_drain_load();
        bus.in_sel   = 2'd1;
        bus.in_data  = 8'h22;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'h11;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ready got %b want 0", bus.in_ready);
        end
        tick();
        vectors++;
        if (chd(1) !== 8'h22 || bus.out_valid !== 4'b0110) begin
            errors++; $display("FAIL stall_hold got %h/%b want 22/0110", chd(1), bus.out_valid);
        end
        bus.out_ready = 4'b0010;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL comb_ready got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        vectors++;
        if (chd(1) !== 8'h11 || bus.out_valid !== 4'b0110 || cnt(1) !== 8'd2) begin
            errors++; $display("FAIL drain_load got %h/%b/%0d want 11/0110/2", chd(1), bus.out_valid, cnt(1));
        end
    endtask

    task automatic test_independent();
        bus.in_sel   = 2'd3;
        bus.in_data  = 8'h33;
        bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 4'b0001;
        bus.in_sel    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'h40 + 8'(i);
            #1;
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL indep_ready beat %0d got %b want 1", i, bus.in_ready);
            end
            tick();
            vectors++;
            if (chd(0) !== 8'h40 + 8'(i) || !bus.out_valid[0] || chd(3) !== 8'h33 || !bus.out_valid[3]) begin
                errors++; $display("FAIL indep beat %0d got ch0 %h ch3 %h valid %b want %h 33",
                                   i, chd(0), chd(3), bus.out_valid, 8'h40 + 8'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        vectors++;
        if (bus.out_valid[0] !== 1'b0 || chd(0) !== 8'h43 || cnt(0) !== 8'd4) begin
            errors++; $display("FAIL indep_drain got %b/%h/%0d want 0/43/4", bus.out_valid[0], chd(0), cnt(0));
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.rr_en     = 1'b1;
        bus.out_ready = 4'b1111;
        bus.in_sel    = 2'd3;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'(i);
            #1;
            vectors++;
            if (rr_ptr !== 2'(i % 4)) begin
                errors++; $display("FAIL rr_ptr beat %0d got %0d want %0d", i, rr_ptr, i % 4);
            end
            tick();
            vectors++;
            if (chd(i % 4) !== 8'(i) || !bus.out_valid[i % 4]) begin
                errors++; $display("FAIL rr_data beat %0d got %h want %h", i, chd(i % 4), 8'(i));
            end
        end
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (rr_ptr !== 2'd0 || beat_cnt !== 32'h0202_0202) begin
            errors++; $display("FAIL rr_end got %0d/%h want 0/02020202", rr_ptr, beat_cnt);
        end
    endtask

    task automatic test_rr_stall();
        do_reset();
        bus.rr_en     = 1'b1;
        bus.out_ready = 4'b1101;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'h50 + 8'(i);
            tick();
        end
        bus.in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 1'b0 || rr_ptr !== 2'd1 || chd(1) !== 8'h51) begin
                errors++; $display("FAIL rr_stall cyc %0d got rdy %b ptr %0d ch1 %h want 0 1 51",
                                   i, bus.in_ready, rr_ptr, chd(1));
            end
            tick();
        end
        bus.out_ready = 4'b1111;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rr_release got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (chd(1) !== 8'h55 || rr_ptr !== 2'd2 || cnt(1) !== 8'd2) begin
            errors++; $display("FAIL rr_resume got %h/%0d/%0d want 55/2/2", chd(1), rr_ptr, cnt(1));
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        bus.out_ready = 4'b0001;
        bus.in_sel    = 2'd0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.in_data = 8'(i);
            tick();
            if (i == 254) begin
                vectors++;
                if (cnt(0) !== 8'd255) begin
                    errors++; $display("FAIL cnt_255 got %0d want 255", cnt(0));
                end
            end
        end
        vectors++;
        if (cnt(0) !== 8'd0 || chd(0) !== 8'hFF) begin
            errors++; $display("FAIL cnt_wrap got %0d/%h want 0/ff", cnt(0), chd(0));
        end
        bus.out_ready = 4'b1111;
        bus.rr_en     = 1'b1;
        bus.in_data   = 8'h70;
        tick();
        bus.out_ready = 4'b0000;
        bus.in_data   = 8'h71;
        tick();
        bus.in_data = 8'h72;
        tick();
        #1;
        vectors++;
        if (bus.out_valid !== 4'b0111 || rr_ptr !== 2'd3 || beat_cnt !== 32'h0001_0101) begin
            errors++; $display("FAIL pre_reset got %b/%0d/%h want 0111/3/00010101", bus.out_valid, rr_ptr, beat_cnt);
        end
        reset       = 1'b1;
        bus.in_data = 8'h73;
        tick();
        vectors++;
        if (bus.out_valid !== 4'b0000 || beat_cnt !== 32'h0 || rr_ptr !== 2'd0 || bus.out_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset got %b/%h/%0d/%h want 0000/0/0/0",
                               bus.out_valid, beat_cnt, rr_ptr, bus.out_data);
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_drain_load();
        test_independent();
        test_round_robin();
        test_rr_stall();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
